// File: rtl/eq_dispatcher_if.sv
// Command/status port between the dispatcher (master) and the event queue wrapper (slave).
interface eq_dispatcher_if #(
  parameter int data_wd = 32
);
  logic               eq_cs;
  logic               eq_op;
  logic [data_wd-1:0] eq_EV_in;
  logic               eq_is_zero_delay;
  logic [data_wd-1:0] eq_EV_out;
  logic               eq_dv;
  logic               eq_full;
  logic               eq_empty;
  logic               eq_busy_rd;
  logic               eq_busy_wr;

  modport master (
    output eq_cs, eq_op, eq_EV_in, eq_is_zero_delay,
    input  eq_EV_out, eq_dv, eq_full, eq_empty, eq_busy_rd, eq_busy_wr
  );

  modport slave (
    input  eq_cs, eq_op, eq_EV_in, eq_is_zero_delay,
    output eq_EV_out, eq_dv, eq_full, eq_empty, eq_busy_rd, eq_busy_wr
  );
endinterface

// File: rtl/eq_dispatcher.sv
// Event queue dispatcher: insert-priority arbitration, extract with dv wait/timeout,
// one-entry output register and simulation-time tracking.
module eq_dispatcher #(
  parameter int data_wd    = 32,
  parameter int hi         = 15,
  parameter int lo         = 0,
  parameter int dv_timeout = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               ins_valid,
  input  logic [data_wd-1:0] ins_ev,
  input  logic               ins_zero_delay,
  output logic               ins_ready,
  output logic               ev_valid,
  output logic [data_wd-1:0] ev_data,
  input  logic               ev_ready,
  output logic [hi-lo:0]     cur_time,
  output logic               time_adv,
  output logic               err,
  output logic               idle,
  eq_dispatcher_if.master    eq
);

  localparam logic INSERT_CMD  = 1'b0;
  localparam logic EXTRACT_CMD = 1'b1;
  localparam int   tw          = $clog2(dv_timeout + 1);
  localparam logic [tw-1:0] timeout_val = tw'(dv_timeout);

  typedef enum logic {IDLE, WAIT_DV} state_t;

  state_t          state;
  state_t          next_state;
  logic [tw-1:0]   timer;
  logic            do_extract;
  logic            capture;
  logic            timeout_hit;
  logic [hi-lo:0]  cap_time;

  assign cap_time            = eq.eq_EV_out[hi:lo];
  assign eq.eq_EV_in         = ins_ev;
  assign eq.eq_is_zero_delay = ins_zero_delay;
  assign idle = (state == IDLE) && !ev_valid && eq.eq_empty && !ins_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Inserts always win over extracts; an extract waits until the output register can take the result.
  always_comb begin
    next_state  = state;
    eq.eq_cs    = 1'b0;
    eq.eq_op    = INSERT_CMD;
    ins_ready   = 1'b0;
    do_extract  = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (ins_valid && !eq.eq_full && !eq.eq_busy_wr) begin
          eq.eq_cs  = 1'b1;
          eq.eq_op  = INSERT_CMD;
          ins_ready = 1'b1;
        end else if (run && !eq.eq_empty && !eq.eq_busy_rd && (!ev_valid || ev_ready)) begin
          eq.eq_cs   = 1'b1;
          eq.eq_op   = EXTRACT_CMD;
          do_extract = 1'b1;
          next_state = WAIT_DV;
        end
      end
      WAIT_DV: begin
        if (eq.eq_dv) begin
          capture    = 1'b1;
          next_state = IDLE;
        end else if (timer == timeout_val) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  timer <= '0;
    else if (do_extract)       timer <= '0;
    else if (state == WAIT_DV) timer <= timer + 1'b1;
  end

  // A capture in the same cycle as a consume keeps the register full with the new event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid <= 1'b0;
      ev_data  <= '0;
    end else if (capture) begin
      ev_valid <= 1'b1;
      ev_data  <= eq.eq_EV_out;
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_time <= '0;
      time_adv <= 1'b0;
      err      <= 1'b0;
    end else begin
      time_adv <= 1'b0;
      if (capture && (cap_time > cur_time)) begin
        cur_time <= cap_time;
        time_adv <= 1'b1;
      end
      if ((capture && (cap_time < cur_time)) || timeout_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eq_dispatcher.sv
// Directed bench for eq_dispatcher: a small behavioural queue drives the status port and a
// spec-level model is compared against the DUT on every falling edge.
module tb_eq_dispatcher;

  localparam int   data_wd    = 32;
  localparam int   dv_timeout = 15;
  localparam int   qcap       = 8;
  localparam logic INSERT_CMD  = 1'b0;
  localparam logic EXTRACT_CMD = 1'b1;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               ins_valid;
  logic [data_wd-1:0] ins_ev;
  logic               ins_zero_delay;
  logic               ins_ready;
  logic               ev_valid;
  logic [data_wd-1:0] ev_data;
  logic               ev_ready;
  logic [15:0]        cur_time;
  logic               time_adv;
  logic               err;
  logic               idle;

  eq_dispatcher_if #(.data_wd(data_wd)) eq();

  eq_dispatcher #(.data_wd(data_wd), .hi(15), .lo(0), .dv_timeout(dv_timeout)) dut (
    .clk(clk), .rst(rst), .run(run),
    .ins_valid(ins_valid), .ins_ev(ins_ev), .ins_zero_delay(ins_zero_delay), .ins_ready(ins_ready),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
    .cur_time(cur_time), .time_adv(time_adv), .err(err), .idle(idle),
    .eq(eq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Spec-level model of what the dispatcher must hold.
  bit          m_wait   = 0;
  int          m_waited = 0;
  bit          m_valid  = 0;
  logic [31:0] m_data   = '0;
  logic [15:0] m_time   = '0;
  bit          m_adv    = 0;
  bit          m_err    = 0;

  // Behavioural event queue plus bench-controlled dv overrides.
  logic [31:0] evq[$];
  logic        nxt_dv     = 1'b0;
  logic [31:0] nxt_out    = '0;
  bit          suppress_dv = 0;
  bit          force_dv    = 0;
  logic [31:0] force_data  = '0;

  logic        ins_cond, ext_cond, exp_cs;
  logic [15:0] t;

  initial begin
    eq.eq_dv      = 1'b0;
    eq.eq_EV_out  = '0;
    eq.eq_empty   = 1'b1;
    eq.eq_full    = 1'b0;
    eq.eq_busy_rd = 1'b0;
    eq.eq_busy_wr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      eq.eq_dv     = nxt_dv | force_dv;
      eq.eq_EV_out = force_dv ? force_data : nxt_out;
      eq.eq_empty  = (evq.size() == 0);
      eq.eq_full   = (evq.size() >= qcap);
    end
  end

  always @(negedge clk) begin : compare
    if (!rst) begin
      m_wait = 0; m_waited = 0; m_valid = 0; m_data = '0;
      m_time = '0; m_adv = 0; m_err = 0;
      evq.delete();
      nxt_dv = 1'b0;
    end
    ins_cond = !m_wait && ins_valid && !eq.eq_full && !eq.eq_busy_wr;
    ext_cond = !m_wait && !ins_cond && run && !eq.eq_empty && !eq.eq_busy_rd && (!m_valid || ev_ready);
    exp_cs   = ins_cond || ext_cond;

    check_output("m_ev_valid", 32'(ev_valid), 32'(m_valid));
    check_output("m_ev_data", ev_data, m_data);
    check_output("m_cur_time", 32'(cur_time), 32'(m_time));
    check_output("m_time_adv", 32'(time_adv), 32'(m_adv));
    check_output("m_err", 32'(err), 32'(m_err));
    check_output("m_eq_cs", 32'(eq.eq_cs), 32'(exp_cs));
    check_output("m_ins_ready", 32'(ins_ready), 32'(ins_cond));
    if (exp_cs) check_output("m_eq_op", 32'(eq.eq_op), ins_cond ? 32'(INSERT_CMD) : 32'(EXTRACT_CMD));
    check_output("m_eq_EV_in", eq.eq_EV_in, ins_ev);
    check_output("m_eq_zd", 32'(eq.eq_is_zero_delay), 32'(ins_zero_delay));
    check_output("m_idle", 32'(idle), 32'(!m_wait && !m_valid && eq.eq_empty && !ins_valid));

    if (rst) begin
      m_adv = 0;
      if (m_valid && ev_ready) m_valid = 0;
      if (m_wait) begin
        if (eq.eq_dv) begin
          t = eq.eq_EV_out[15:0];
          if (t > m_time) begin
            m_time = t;
            m_adv  = 1;
          end else if (t < m_time) begin
            m_err = 1;
          end
          m_valid = 1;
          m_data  = eq.eq_EV_out;
          m_wait  = 0;
        end else if (m_waited + 1 > dv_timeout) begin
          m_err  = 1;
          m_wait = 0;
        end else begin
          m_waited++;
        end
      end
      if (ext_cond) begin
        m_wait   = 1;
        m_waited = 0;
      end

      nxt_dv = 1'b0;
      if (eq.eq_cs && eq.eq_op == INSERT_CMD && evq.size() < qcap) evq.push_back(eq.eq_EV_in);
      if (eq.eq_cs && eq.eq_op == EXTRACT_CMD) begin
        if (evq.size() > 0) nxt_out = evq.pop_front();
        nxt_dv = !suppress_dv;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] ev, input logic zd);
    ins_valid      = v;
    ins_ev         = ev;
    ins_zero_delay = zd;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (ev_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s actual=ev_valid_low required=ev_valid_high", name);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    ev_ready = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_ev_valid", 32'(ev_valid), 32'h0);
    check_output("rst_ev_data", ev_data, 32'h0);
    check_output("rst_cur_time", 32'(cur_time), 32'h0);
    check_output("rst_err", 32'(err), 32'h0);
    check_output("rst_eq_cs", 32'(eq.eq_cs), 32'h0);
    check_output("rst_idle", 32'(idle), 32'h1);
    tick();
    rst = 1'b1;

    // Single insert is issued combinationally.
    tick();
    apply_stimulus(1'b1, 32'h0000_0005, 1'b0);
    @(negedge clk);
    check_output("ins_cs", 32'(eq.eq_cs), 32'h1);
    check_output("ins_op", 32'(eq.eq_op), 32'(INSERT_CMD));
    check_output("ins_ready", 32'(ins_ready), 32'h1);
    check_output("ins_EV_in", eq.eq_EV_in, 32'h0000_0005);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0);

    // Extract time 5 and deliver it.
    run = 1'b1;
    ev_ready = 1'b1;
    wait_valid("t5_wait");
    check_output("t5_data", ev_data, 32'h0000_0005);
    check_output("t5_time", 32'(cur_time), 32'h5);
    check_output("t5_adv", 32'(time_adv), 32'h1);
    @(negedge clk);
    check_output("t5_adv_off", 32'(time_adv), 32'h0);
    tick();
    run = 1'b0;

    // Insert and extract contend in the same cycle.
    ev_ready = 1'b0;
    apply_stimulus(1'b1, 32'h0000_0007, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h0000_0009, 1'b1);
    run = 1'b1;
    @(negedge clk);
    check_output("prio_op", 32'(eq.eq_op), 32'(INSERT_CMD));
    check_output("prio_ready", 32'(ins_ready), 32'h1);
    check_output("prio_zd", 32'(eq.eq_is_zero_delay), 32'h1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("prio_ext_cs", 32'(eq.eq_cs), 32'h1);
    check_output("prio_ext_op", 32'(eq.eq_op), 32'(EXTRACT_CMD));
    wait_valid("t7_wait");
    check_output("t7_data", ev_data, 32'h0000_0007);
    check_output("t7_time", 32'(cur_time), 32'h7);

    // Output register full and not drained: no extract.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("hold_no_cs", 32'(eq.eq_cs), 32'h0);
      check_output("hold_data", ev_data, 32'h0000_0007);
    end
    tick();
    ev_ready = 1'b1;
    @(negedge clk);
    check_output("drain_cs", 32'(eq.eq_cs), 32'h1);
    check_output("drain_op", 32'(eq.eq_op), 32'(EXTRACT_CMD));
    wait_valid("t9_wait");
    check_output("t9_data", ev_data, 32'h0000_0009);
    check_output("t9_time", 32'(cur_time), 32'h9);
    tick();
    run = 1'b0;

    // Event in the past: still delivered, flagged.
    apply_stimulus(1'b1, 32'h0000_0003, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0);
    run = 1'b1;
    wait_valid("t3_wait");
    check_output("t3_err", 32'(err), 32'h1);
    check_output("t3_data", ev_data, 32'h0000_0003);
    check_output("t3_time", 32'(cur_time), 32'h9);
    tick();
    run = 1'b0;

    rst = 1'b0;
    @(negedge clk);
    check_output("rst2_err", 32'(err), 32'h0);
    check_output("rst2_time", 32'(cur_time), 32'h0);
    tick();
    rst = 1'b1;

    // dv never arrives: abort after the full wait window.
    suppress_dv = 1;
    apply_stimulus(1'b1, 32'h0000_0004, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0);
    run = 1'b1;
    @(negedge clk);
    check_output("to_ext_cs", 32'(eq.eq_cs), 32'h1);
    repeat (16) @(negedge clk);
    check_output("to_not_early", 32'(err), 32'h0);
    @(negedge clk);
    check_output("to_err", 32'(err), 32'h1);
    check_output("to_idle", 32'(idle), 32'h1);
    check_output("to_no_ev", 32'(ev_valid), 32'h0);
    tick();
    run = 1'b0;

    // Reset while waiting, then a stale dv.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    apply_stimulus(1'b1, 32'h0000_0006, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0);
    run = 1'b1;
    @(negedge clk);
    check_output("rw_ext_cs", 32'(eq.eq_cs), 32'h1);
    tick();
    tick();
    rst = 1'b0;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    force_data = 32'h0000_0006;
    force_dv   = 1;
    @(negedge clk);
    force_dv   = 0;
    repeat (3) @(negedge clk);
    check_output("rw_no_ev", 32'(ev_valid), 32'h0);
    check_output("rw_time", 32'(cur_time), 32'h0);
    check_output("rw_err", 32'(err), 32'h0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eq_dispatcher.md
Name: eq_dispatcher

Overview:
- Initiator-side controller for the event queue wrapper; it is the only block that drives the queue's cs/op command port.
- Arbitrates insert requests from the evaluation units against extract requests.
- Issues one-cycle queue commands and captures extracted events into a one-entry output register with a valid/ready handshake toward the gate-evaluation pipeline.
- Tracks current simulation time and flags causality violations and lost data-valid responses.

Parameters:
- data_wd, 32, width of one event entry (matches the queue).
- hi, 15, TIME field high bit in the entry.
- lo, 0, TIME field low bit in the entry.
- dv_timeout, 15, maximum cycles in WAIT_DV before abort (timer width 4 bits at default; sized as clog2(dv_timeout+1)).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  enables extraction; inserts are served regardless.
- ins_valid  in  1  insert request from evaluation units.
- ins_ev  in  data_wd  entry to insert.
- ins_zero_delay  in  1  route this insert to the zero-delay FIFO.
- ins_ready  out  1  insert accepted this cycle (combinational).
- ev_valid  out  1  output register holds an event.
- ev_data  out  data_wd  extracted event.
- ev_ready  in  1  downstream consumes ev_data when ev_valid=1.
- cur_time  out  hi-lo+1  current simulation time.
- time_adv  out  1  one-cycle pulse when cur_time increases.
- err  out  1  sticky: causality violation or dv timeout.
- idle  out  1  nothing pending anywhere.
- eq_cs, eq_op  out  1 each  queue command; op uses INSERT_CMD/EXTRACT_CMD from the common defines.
- eq_EV_in  out  data_wd  entry to queue (equals ins_ev).
- eq_is_zero_delay  out  1  equals ins_zero_delay.
- eq_EV_out  in  data_wd  queue output entry.
- eq_dv, eq_full, eq_empty, eq_busy_rd, eq_busy_wr  in  1 each  queue status.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - ev_valid=0, ev_data=0, cur_time=0, time_adv=0, err=0, timer=0.
  - Combinational outputs follow from this state: eq_cs=0, ins_ready=0 unless the IDLE insert condition holds.
  - A reset in WAIT_DV drops the outstanding extract; a late eq_dv after reset is ignored because the state is IDLE.
- FSM states: IDLE and WAIT_DV.
- IDLE, insert (highest priority):
  - Condition: ins_valid & !eq_full & !eq_busy_wr.
  - Drive eq_cs=1, eq_op=INSERT_CMD, ins_ready=1; remain in IDLE.
  - Inserts are accepted back-to-back, one per cycle.
- IDLE, extract:
  - Condition: no insert this cycle, run & !eq_empty & !eq_busy_rd, and (ev_valid=0 or ev_ready=1).
  - Drive eq_cs=1, eq_op=EXTRACT_CMD; go to WAIT_DV; clear timer.
  - Strict insert priority: pending inserts always complete before the next extract.
- WAIT_DV:
  - eq_cs=0, ins_ready=0, timer increments each cycle.
  - On eq_dv=1 (same cycle as the command is not possible; earliest is the next cycle): ev_data<=eq_EV_out, ev_valid<=1, return to IDLE.
  - If timer reaches dv_timeout without eq_dv: err<=1, return to IDLE, no event delivered.
- Output register:
  - ev_valid clears when ev_valid & ev_ready, unless a capture happens in the same cycle; a capture wins and ev_valid stays 1.
  - ev_data is stable while ev_valid=1 & ev_ready=0.
- Time tracking on capture, with t = eq_EV_out[hi:lo]:
  - t > cur_time: cur_time<=t and time_adv=1 for one cycle.
  - t == cur_time: no change.
  - t < cur_time: err<=1; event still delivered; cur_time unchanged.
  - Unsigned comparison; no wrap-around handling, since time is monotonic by contract.
- Once set, err clears only on reset.
- idle = (state==IDLE) & !ev_valid & eq_empty & !ins_valid.
- run=0 in WAIT_DV does not abort the extract; the outstanding response still completes.

Test Plan:
- Reset then ins_valid=1 with ins_ev=0x0000_0005 and eq_full=0 -> same cycle eq_cs=1, eq_op=INSERT_CMD, ins_ready=1, eq_EV_in=0x0000_0005.
- Queue holding time 5, run=1, ev_ready=1, eq_dv one cycle after the command with eq_EV_out=0x0000_0005 -> ev_valid=1, ev_data=0x0000_0005, cur_time=5, time_adv pulses once.
- ins_valid and an extract condition in the same cycle -> insert issued first, extract issued the following cycle; never two eq_cs commands in one cycle.
- ev_ready=0 holding one event, queue non-empty -> no extract issued; raise ev_ready -> extract issued in that same cycle.
- Capture time 3 after cur_time=5 -> err=1, ev_data delivered, cur_time stays 5; eq_dv withheld for 16 cycles -> err=1, FSM back in IDLE.
- rst asserted in WAIT_DV, eq_dv pulsed after release -> ev_valid stays 0, cur_time=0.
